// File: rtl/cpu_bus_pkg.sv
// Shared 6502 internal-bus definitions: register indices, transfer sequencer states, idle bus level.
// No logic, no latency, no backpressure.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    AC  = 3'd0,
    X   = 3'd1,
    Y   = 3'd2,
    SP  = 3'd3,
    PCL = 3'd4,
    PCH = 3'd5,
    DL  = 3'd6,
    ALU = 3'd7
  } bus_reg_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    LATCH   = 2'd2,
    RELEASE = 2'd3
  } xfer_state_e;

  // The open-drain bus floats to all ones when no source drives it.
  localparam logic [7:0] BUS_IDLE_VALUE = 8'hFF;

endpackage

// File: rtl/onehot_decoder.sv
// Index to one-hot decoder with enable; an index at or above N yields all zeros.
// Combinational, zero latency, no backpressure.
module onehot_decoder #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (int'(idx) == i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Break-before-make sequencer for register-to-register transfers on the shared latch bus.
// Latency: drive at N+1, latch at N+2, release/done at N+3; ready only in IDLE/RELEASE and never during flush.
module bus_transfer_sequencer
  import cpu_bus_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDX_W-1:0]    req_src,
  input  logic [IDX_W-1:0]    req_dst,
  input  logic                req_dbus,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busWrite_EN,
  output logic [NUM_REGS-1:0] busRead_EN,
  output logic                dataBusWrite_EN,
  output logic                done,
  output logic                err
);

  xfer_state_e         state_q, state_d;
  logic [IDX_W-1:0]    src_q, src_d;
  logic [IDX_W-1:0]    dst_q, dst_d;
  logic                dbus_q, dbus_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [NUM_REGS-1:0] rd_en_q, rd_en_d;
  logic                dbw_q, dbw_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic accept;
  logic legal;
  logic wr_act;
  logic rd_act;

  assign req_ready = ((state_q == IDLE) || (state_q == RELEASE)) && !flush;
  assign accept    = req_valid && req_ready;
  assign legal     = (req_src != req_dst) &&
                     (int'(req_src) < NUM_REGS) &&
                     (int'(req_dst) < NUM_REGS);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    dbus_d  = dbus_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            src_d   = req_src;
            dst_d   = req_dst;
            dbus_d  = req_dbus;
            state_d = DRIVE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        state_d = flush ? IDLE : LATCH;
      end
      // The latch must close cleanly, so flush only cancels the completion report.
      LATCH: begin
        state_d = RELEASE;
        done_d  = !flush;
      end
      RELEASE: begin
        state_d = IDLE;
        if (accept) begin
          if (legal) begin
            src_d   = req_src;
            dst_d   = req_dst;
            dbus_d  = req_dbus;
            state_d = DRIVE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Enables are decoded from the next state so they come straight off flops.
  assign wr_act = (state_d != IDLE);
  assign rd_act = (state_d == LATCH);
  assign dbw_d  = dbus_d && wr_act;

  onehot_decoder #(.N(NUM_REGS), .IDX_W(IDX_W)) u_src_dec (
    .en     (wr_act),
    .idx    (src_d),
    .onehot (wr_en_d)
  );

  onehot_decoder #(.N(NUM_REGS), .IDX_W(IDX_W)) u_dst_dec (
    .en     (rd_act),
    .idx    (dst_d),
    .onehot (rd_en_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      dbus_q  <= 1'b0;
      wr_en_q <= '0;
      rd_en_q <= '0;
      dbw_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      dbus_q  <= dbus_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      dbw_q   <= dbw_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busWrite_EN     = wr_en_q;
  assign busRead_EN      = rd_en_q;
  assign dataBusWrite_EN = dbw_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Scoreboard bench: stimulus pushes expected non-idle output cycles, a negedge monitor pops and compares.
module tb_bus_transfer_sequencer;

  typedef struct packed {
    logic [15:0] cyc;
    logic [7:0]  wr;
    logic [7:0]  rd;
    logic        dbw;
    logic        dn;
    logic        er;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_src = '0;
  logic [3:0] req_dst = '0;
  logic       req_dbus = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] busWrite_EN;
  logic [7:0] busRead_EN;
  logic       dataBusWrite_EN;
  logic       done;
  logic       err;

  int  cyc = 0;
  int  n_total = 0;
  int  n_pass = 0;
  int  n;
  ev_t exp_q[$];
  ev_t mon_act;
  ev_t mon_exp;

  bus_transfer_sequencer #(.NUM_REGS(8), .IDX_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_src         (req_src),
    .req_dst         (req_dst),
    .req_dbus        (req_dbus),
    .flush           (flush),
    .busWrite_EN     (busWrite_EN),
    .busRead_EN      (busRead_EN),
    .dataBusWrite_EN (dataBusWrite_EN),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic present(input logic [3:0] s, input logic [3:0] d, input logic db);
    req_valid = 1'b1;
    req_src   = s;
    req_dst   = d;
    req_dbus  = db;
  endtask

  task automatic push(input int c, input logic [7:0] wr, input logic [7:0] rd,
                      input logic dbw, input logic dn, input logic er);
    ev_t e;
    e.cyc = c[15:0];
    e.wr  = wr;
    e.rd  = rd;
    e.dbw = dbw;
    e.dn  = dn;
    e.er  = er;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with any asserted output must match the next expected record.
  always @(negedge clk) begin
    if (!rst && ((busWrite_EN != 8'h00) || (busRead_EN != 8'h00) ||
                 dataBusWrite_EN || done || err)) begin
      mon_act.cyc = cyc[15:0];
      mon_act.wr  = busWrite_EN;
      mon_act.rd  = busRead_EN;
      mon_act.dbw = dataBusWrite_EN;
      mon_act.dn  = done;
      mon_act.er  = err;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got %h, required no output activity", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("sb_event", 64'(mon_act), 64'(mon_exp));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    chk("rst_busWrite", 64'(busWrite_EN), 64'd0);
    chk("rst_busRead", 64'(busRead_EN), 64'd0);
    chk("rst_dataBusWrite", 64'(dataBusWrite_EN), 64'd0);
    chk("rst_done_err", 64'({done, err}), 64'd0);
    step(2);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    // Flush in IDLE blocks acceptance; no activity may follow.
    flush = 1'b1;
    present(4'd1, 4'd2, 1'b0);
    #1;
    chk("ready_flush_idle", 64'(req_ready), 64'd0);
    step(1);
    req_valid = 1'b0;
    flush = 1'b0;
    step(4);

    // Single transfer AC -> X.
    n = cyc;
    present(4'd0, 4'd1, 1'b0);
    push(n + 1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    push(n + 2, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    push(n + 3, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1);
    req_valid = 1'b0;
    step(5);

    // Back-to-back AC -> Y then SP -> DL; second accepted in RELEASE.
    n = cyc;
    present(4'd0, 4'd2, 1'b0);
    push(n + 1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    push(n + 2, 8'h01, 8'h04, 1'b0, 1'b0, 1'b0);
    push(n + 3, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    push(n + 4, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0);
    push(n + 5, 8'h08, 8'h40, 1'b0, 1'b0, 1'b0);
    push(n + 6, 8'h08, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1);
    present(4'd3, 4'd6, 1'b0);
    step(3);
    req_valid = 1'b0;
    step(5);

    // Illegal requests: src == dst, then destination out of range.
    n = cyc;
    present(4'd3, 4'd3, 1'b0);
    push(n + 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1);
    present(4'd0, 4'd9, 1'b0);
    push(n + 2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1);
    req_valid = 1'b0;
    step(4);

    // Flush in DRIVE: back to IDLE, no latch enable, no done.
    n = cyc;
    present(4'd1, 4'd2, 1'b0);
    push(n + 1, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1);
    req_valid = 1'b0;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(4);

    // Flush in LATCH: latch completes and releases, done suppressed.
    n = cyc;
    present(4'd4, 4'd5, 1'b0);
    push(n + 1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
    push(n + 2, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    push(n + 3, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1);
    req_valid = 1'b0;
    step(1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(4);

    // Data bus drive ALU -> AC.
    n = cyc;
    present(4'd7, 4'd0, 1'b1);
    push(n + 1, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0);
    push(n + 2, 8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
    push(n + 3, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1);
    req_valid = 1'b0;
    req_dbus = 1'b0;
    step(5);

    // Asynchronous reset while in LATCH.
    n = cyc;
    present(4'd2, 4'd6, 1'b0);
    push(n + 1, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0);
    push(n + 2, 8'h04, 8'h40, 1'b0, 1'b0, 1'b0);
    step(1);
    req_valid = 1'b0;
    step(1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busWrite", 64'(busWrite_EN), 64'd0);
    chk("arst_busRead", 64'(busRead_EN), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_ready", 64'(req_ready), 64'd1);
    step(2);

    // Normal transfer SP -> PCH after the reset shows a clean IDLE.
    n = cyc;
    present(4'd3, 4'd5, 1'b0);
    push(n + 1, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0);
    push(n + 2, 8'h08, 8'h20, 1'b0, 1'b0, 1'b0);
    push(n + 3, 8'h08, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1);
    req_valid = 1'b0;
    step(5);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_transfer_sequencer.md
Name: bus_transfer_sequencer

Overview:
- Sequences register-to-register transfers over the shared 8-bit system bus of the 6502 core.
- Bus registers (AC, X, Y, SP, PCL, PCH, DL, ALU out) are latch-based. They open-drain onto the bus, with the idle bus pulled to 8'hFF.
- For each transfer request, this block generates the one-hot source-write and destination-read enables. The sequence is break-before-make, so a transparent destination latch never sees a changing or undriven bus.
- It sits between the instruction decoder (requester) and the register file enables.

Parameters:
- NUM_REGS, 8, number of bus registers (one enable bit each); legal range 2..16.
- IDX_W, $clog2(NUM_REGS), width of source/destination index.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  decoder presents a transfer
- req_ready  output  1  sequencer accepts on req_valid && req_ready
- req_src  input  IDX_W  source register index
- req_dst  input  IDX_W  destination register index
- req_dbus  input  1  source also drives the data bus (dataBusWrite_EN) during the transfer
- flush  input  1  abandon the current transfer (interrupt/reset vector entry)
- busWrite_EN  output  NUM_REGS  one-hot source drive enables
- busRead_EN  output  NUM_REGS  one-hot destination latch enables
- dataBusWrite_EN  output  1  data bus drive enable
- done  output  1  one-cycle pulse when a transfer completes
- err  output  1  one-cycle pulse for a rejected request

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- Reset values: state=IDLE; busWrite_EN=0, busRead_EN=0, dataBusWrite_EN=0, done=0, err=0; req_ready=1 after reset release.
- States: IDLE, DRIVE, LATCH, RELEASE. The state register is held in an enum; all enables are registered outputs decoded from state plus the captured src/dst/dbus.
- IDLE
  - req_ready=1.
  - On accept with req_src!=req_dst and both < NUM_REGS: capture src/dst/dbus and go to DRIVE.
  - On accept with src==dst or an index out of range: pulse err next cycle and stay IDLE. No enables assert.
- DRIVE (1 cycle)
  - busWrite_EN[src]=1; dataBusWrite_EN=dbus.
  - busRead_EN=0 (bus settling).
  - Next state is LATCH, or IDLE if flush.
- LATCH (1 cycle)
  - busWrite_EN[src]=1 and busRead_EN[dst]=1.
  - Next state is RELEASE unconditionally. flush is ignored here; the latch must be closed cleanly.
- RELEASE (1 cycle)
  - busWrite_EN[src] stays 1; busRead_EN=0. This guarantees hold time on the destination latch.
  - done=1 in this cycle, unless a flush occurred in LATCH (then done=0).
  - req_ready=1.
  - A valid request accepted here goes directly to DRIVE (back-to-back). Otherwise go to IDLE.
- Latency and throughput: accept at cycle N. DRIVE is N+1, LATCH is N+2, RELEASE/done is N+3. Back-to-back throughput is one transfer per 3 cycles.
- Invariants:
  - popcount(busWrite_EN)<=1 and popcount(busRead_EN)<=1.
  - busRead_EN never asserts in a cycle where busWrite_EN changes.
  - dataBusWrite_EN implies busWrite_EN!=0.
- flush in IDLE or RELEASE:
  - It suppresses acceptance that cycle (req_ready forced 0).
  - In RELEASE, the current done still pulses unless the flush was latched in LATCH.
- rst mid-operation: all enables drop asynchronously and the captured request is discarded.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - enum bus_reg_e (AC=0, X=1, Y=2, SP=3, PCL=4, PCH=5, DL=6, ALU=7);
  - enum xfer_state_e (IDLE, DRIVE, LATCH, RELEASE);
  - constant BUS_IDLE_VALUE=8'hFF.
- One natural sub-module: onehot_decoder (index to NUM_REGS-wide one-hot with enable), instantiated twice for the source and destination enables.

Test Plan:
- Reset then single transfer: src=AC(0), dst=X(1), dbus=0. Required response:
  - busWrite_EN=8'h01 at N+1..N+3;
  - busRead_EN=8'h02 only at N+2;
  - done at N+3.
- Back-to-back: hold req_valid with AC->Y, then SP->DL. Required response:
  - second accept in RELEASE;
  - busWrite_EN goes 8'h01 -> 8'h08 with no idle cycle;
  - busRead_EN pulses 8'h04 at N+2, then 8'h40 at N+5;
  - two done pulses, 3 cycles apart.
- Illegal request: src=dst=3, then src=0/dst=9 with NUM_REGS=8. Required response: err pulse each; busWrite_EN/busRead_EN stay 0.
- Flush in DRIVE and in LATCH:
  - DRIVE case: returns to IDLE with no busRead_EN and no done.
  - LATCH case: RELEASE still occurs with busRead_EN already low, and done stays 0.
- Async reset asserted in LATCH. Required response: all enables 0 before the next clock edge; after release, req_ready=1 and state is IDLE.
- dbus=1 transfer ALU->AC. Required response: dataBusWrite_EN=1 exactly N+1..N+3, coincident with busWrite_EN=8'h80.
